// File: rtl/transport_ctrl_if.sv
// Transport sequencer bus: command/tick/done inputs and request/strobe/status outputs.
// The master side drives commands and ticks; the slave side is transport_ctrl.
interface transport_ctrl_if #(
  parameter int unsigned ADDR_W = 21
);
  logic              rec_cmd;
  logic              play_cmd;
  logic              stop_cmd;
  logic              sample_tick;
  logic              store_done;
  logic              store_req;
  logic              load_req;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] playhead;
  logic [ADDR_W-1:0] track_len;
  logic [1:0]        state;
  logic              overflow;

  modport master (
    output rec_cmd, play_cmd, stop_cmd, sample_tick, store_done,
    input  store_req, load_req, wr_en, rd_en, playhead, track_len, state, overflow
  );

  modport slave (
    input  rec_cmd, play_cmd, stop_cmd, sample_tick, store_done,
    output store_req, load_req, wr_en, rd_en, playhead, track_len, state, overflow
  );
endinterface

// File: rtl/transport_ctrl.sv
// Record/play/stop transport sequencer for the single-track SD store/load path.
// Define TRANSPORT_LOOP_EN to make playback wrap at end of track instead of stopping.
module transport_ctrl #(
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned MAX_SAMPLES = 1323000
) (
  input  logic             clk,
  input  logic             rst_n,
  transport_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REC   = 2'd1,
    S_FLUSH = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] FULL_LEN = ADDR_W'(MAX_SAMPLES);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t            r_state,     w_state_nxt;
  logic [ADDR_W-1:0] r_playhead,  w_playhead_nxt;
  logic [ADDR_W-1:0] r_track_len, w_track_len_nxt;
  logic              r_overflow,  w_overflow_nxt;
  logic              r_store_req, w_store_req_nxt;
  logic              r_load_req,  w_load_req_nxt;
  logic              r_wr_en,     w_wr_en_nxt;
  logic              r_rd_en,     w_rd_en_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_playhead  <= '0;
      r_track_len <= '0;
      r_overflow  <= 1'b0;
      r_store_req <= 1'b0;
      r_load_req  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_playhead  <= w_playhead_nxt;
      r_track_len <= w_track_len_nxt;
      r_overflow  <= w_overflow_nxt;
      r_store_req <= w_store_req_nxt;
      r_load_req  <= w_load_req_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_playhead_nxt  = r_playhead;
    w_track_len_nxt = r_track_len;
    w_overflow_nxt  = r_overflow;
    w_store_req_nxt = r_store_req;
    w_load_req_nxt  = r_load_req;
    w_wr_en_nxt     = 1'b0;
    w_rd_en_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // stop_cmd outranks the others yet does nothing here, so it masks them
        if (!bus.stop_cmd) begin
          if (bus.rec_cmd) begin
            w_state_nxt     = S_REC;
            w_playhead_nxt  = '0;
            w_overflow_nxt  = 1'b0;
            w_store_req_nxt = 1'b1;
          end else if (bus.play_cmd && (r_track_len != '0)) begin
            w_state_nxt    = S_PLAY;
            w_playhead_nxt = '0;
            w_load_req_nxt = 1'b1;
          end
        end
      end

      S_REC: begin
        if (bus.stop_cmd) begin
          w_state_nxt = S_FLUSH;
        end else if (bus.sample_tick) begin
          w_wr_en_nxt = 1'b1;
          if (r_playhead == LAST_IDX) begin
            w_playhead_nxt = FULL_LEN;
            w_overflow_nxt = 1'b1;
            w_state_nxt    = S_FLUSH;
          end else begin
            w_playhead_nxt = r_playhead + ONE;
          end
        end
      end

      S_FLUSH: begin
        if (bus.store_done) begin
          w_track_len_nxt = r_playhead;
          w_store_req_nxt = 1'b0;
          w_playhead_nxt  = '0;
          w_state_nxt     = S_IDLE;
        end
      end

      S_PLAY: begin
        if (bus.stop_cmd) begin
          w_state_nxt    = S_IDLE;
          w_load_req_nxt = 1'b0;
          w_playhead_nxt = '0;
        end else if (bus.sample_tick) begin
          w_rd_en_nxt = 1'b1;
          if (r_playhead == (r_track_len - ONE)) begin
            w_playhead_nxt = '0;
`ifdef TRANSPORT_LOOP_EN
            w_state_nxt    = S_PLAY;
`else
            w_load_req_nxt = 1'b0;
            w_state_nxt    = S_IDLE;
`endif
          end else begin
            w_playhead_nxt = r_playhead + ONE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.state     = r_state;
  assign bus.playhead  = r_playhead;
  assign bus.track_len = r_track_len;
  assign bus.overflow  = r_overflow;
  assign bus.store_req = r_store_req;
  assign bus.load_req  = r_load_req;
  assign bus.wr_en     = r_wr_en;
  assign bus.rd_en     = r_rd_en;

endmodule

// File: tb/tb_transport_ctrl.sv
// Self-checking bench for transport_ctrl with MAX_SAMPLES=8, ADDR_W=4.
// Expectations come from per-scenario arithmetic (sample counts, modulo wrap, saturation).
module tb_transport_ctrl;
  localparam int unsigned AW   = 4;
  localparam int unsigned MAXS = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned wr_cnt  = 0;
  int unsigned rd_cnt  = 0;
  int unsigned m_tlen  = 0;

  transport_ctrl_if #(.ADDR_W(AW)) bus ();

  transport_ctrl #(.ADDR_W(AW), .MAX_SAMPLES(MAXS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) wr_cnt++;
    if (bus.rd_en === 1'b1) rd_cnt++;
    if (rst_n) begin
      vectors++;
      if (bus.store_req === 1'b1 && bus.load_req === 1'b1) begin
        errors++;
        $display("FAIL req_exclusive: store_req=1 and load_req=1 at %0t, want never both", $time);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
  endtask

  task automatic pulse_rec();   bus.rec_cmd = 1'b1;    step(); bus.rec_cmd = 1'b0;    endtask
  task automatic pulse_play();  bus.play_cmd = 1'b1;   step(); bus.play_cmd = 1'b0;   endtask
  task automatic pulse_stop();  bus.stop_cmd = 1'b1;   step(); bus.stop_cmd = 1'b0;   endtask
  task automatic pulse_done();  bus.store_done = 1'b1; step(); bus.store_done = 1'b0; endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    vectors++;
    if ({bus.state, bus.playhead, bus.track_len, bus.overflow, bus.store_req,
         bus.load_req, bus.wr_en, bus.rd_en} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d ph=%0d tlen=%0d ovf=%0b sreq=%0b lreq=%0b wr=%0b rd=%0b, want all 0",
               bus.state, bus.playhead, bus.track_len, bus.overflow, bus.store_req,
               bus.load_req, bus.wr_en, bus.rd_en);
    end
    rst_n = 1'b1;
    step();
    m_tlen = 0;
  endtask

  task automatic test_record(input int unsigned n, input bit fixed_gap);
    int unsigned w0, gap;
    pulse_rec();
    vectors++;
    if ({bus.state, bus.store_req, bus.playhead, bus.overflow} !== {2'd1, 1'b1, AW'(0), 1'b0}) begin
      errors++;
      $display("FAIL rec_start: state=%0d sreq=%0b ph=%0d ovf=%0b, want 1/1/0/0",
               bus.state, bus.store_req, bus.playhead, bus.overflow);
    end
    w0 = wr_cnt;
    for (int unsigned k = 0; k < n; k++) begin
      gap = fixed_gap ? 10 : $urandom_range(2, 12);
      tick();
      vectors++;
      if ({bus.wr_en, bus.playhead, bus.state} !== {1'b1, AW'(k + 1), 2'd1}) begin
        errors++;
        $display("FAIL rec_tick%0d: wr=%0b ph=%0d state=%0d, want 1/%0d/1",
                 k, bus.wr_en, bus.playhead, bus.state, k + 1);
      end
      repeat (gap - 1) step();
    end
    pulse_stop();
    vectors++;
    if ({bus.state, bus.playhead, bus.store_req} !== {2'd2, AW'(n), 1'b1}) begin
      errors++;
      $display("FAIL rec_stop: state=%0d ph=%0d sreq=%0b, want 2/%0d/1",
               bus.state, bus.playhead, bus.store_req, n);
    end
    for (int unsigned k = 0; k < 2; k++) begin
      tick();
      repeat (3) step();
    end
    repeat (fixed_gap ? 19 : $urandom_range(4, 19)) step();
    pulse_done();
    vectors++;
    if ({bus.state, bus.store_req, bus.track_len, bus.playhead} !== {2'd0, 1'b0, AW'(n), AW'(0)}) begin
      errors++;
      $display("FAIL flush_done: state=%0d sreq=%0b tlen=%0d ph=%0d, want 0/0/%0d/0",
               bus.state, bus.store_req, bus.track_len, bus.playhead, n);
    end
    vectors++;
    if (wr_cnt - w0 !== n) begin
      errors++;
      $display("FAIL rec_wr_count: got %0d strobes, want %0d", wr_cnt - w0, n);
    end
    m_tlen = n;
  endtask

  task automatic test_play(input int unsigned nticks);
    int unsigned r0, exp_rd_total, gap;
    logic [1:0]    exp_state;
    logic          exp_rd, exp_load;
    int unsigned   exp_ph;
    pulse_play();
    vectors++;
    if ({bus.state, bus.load_req, bus.playhead} !== {2'd3, 1'b1, AW'(0)}) begin
      errors++;
      $display("FAIL play_start: state=%0d lreq=%0b ph=%0d, want 3/1/0",
               bus.state, bus.load_req, bus.playhead);
    end
    r0 = rd_cnt;
    exp_rd_total = 0;
    exp_state = 2'd3;
    for (int unsigned k = 0; k < nticks; k++) begin
      gap = $urandom_range(2, 12);
      tick();
`ifdef TRANSPORT_LOOP_EN
      exp_rd = 1'b1; exp_ph = (k + 1) % m_tlen; exp_state = 2'd3; exp_load = 1'b1;
`else
      if (k < m_tlen) begin
        exp_rd = 1'b1; exp_ph = (k + 1) % m_tlen;
        exp_state = (k + 1 == m_tlen) ? 2'd0 : 2'd3;
        exp_load = (k + 1 < m_tlen);
      end else begin
        exp_rd = 1'b0; exp_ph = 0; exp_state = 2'd0; exp_load = 1'b0;
      end
`endif
      if (exp_rd) exp_rd_total++;
      vectors++;
      if ({bus.rd_en, bus.playhead, bus.state, bus.load_req} !== {exp_rd, AW'(exp_ph), exp_state, exp_load}) begin
        errors++;
        $display("FAIL play_tick%0d: rd=%0b ph=%0d state=%0d lreq=%0b, want %0b/%0d/%0d/%0b",
                 k, bus.rd_en, bus.playhead, bus.state, bus.load_req,
                 exp_rd, exp_ph, exp_state, exp_load);
      end
      repeat (gap - 1) step();
    end
    vectors++;
    if (rd_cnt - r0 !== exp_rd_total) begin
      errors++;
      $display("FAIL play_rd_count: got %0d strobes, want %0d", rd_cnt - r0, exp_rd_total);
    end
    if (exp_state == 2'd3) begin
      pulse_stop();
      vectors++;
      if ({bus.state, bus.load_req, bus.playhead} !== {2'd0, 1'b0, AW'(0)}) begin
        errors++;
        $display("FAIL play_stop: state=%0d lreq=%0b ph=%0d, want 0/0/0",
                 bus.state, bus.load_req, bus.playhead);
      end
    end
  endtask

  task automatic test_overflow();
    int unsigned w0;
    logic [1:0] exp_state;
    pulse_rec();
    w0 = wr_cnt;
    for (int unsigned k = 0; k < 10; k++) begin
      if (k == MAXS - 1) bus.store_done = 1'b1;
      tick();
      bus.store_done = 1'b0;
      exp_state = (k + 1 < MAXS) ? 2'd1 : 2'd2;
      vectors++;
      if ({bus.wr_en, bus.playhead, bus.state, bus.overflow} !==
          {(k < MAXS), AW'((k + 1 < MAXS) ? k + 1 : MAXS), exp_state, (k + 1 >= MAXS)}) begin
        errors++;
        $display("FAIL ovf_tick%0d: wr=%0b ph=%0d state=%0d ovf=%0b", k,
                 bus.wr_en, bus.playhead, bus.state, bus.overflow);
      end
      repeat (4) step();
    end
    vectors++;
    if (wr_cnt - w0 !== MAXS) begin
      errors++;
      $display("FAIL ovf_wr_count: got %0d strobes, want %0d", wr_cnt - w0, MAXS);
    end
    pulse_done();
    vectors++;
    if ({bus.state, bus.track_len, bus.overflow, bus.store_req} !== {2'd0, AW'(MAXS), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_done: state=%0d tlen=%0d ovf=%0b sreq=%0b, want 0/%0d/1/0",
               bus.state, bus.track_len, bus.overflow, bus.store_req, MAXS);
    end
    m_tlen = MAXS;
    pulse_rec();
    vectors++;
    if ({bus.state, bus.overflow} !== {2'd1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_clear: state=%0d ovf=%0b, want 1/0", bus.state, bus.overflow);
    end
    pulse_stop();
    repeat (3) step();
    pulse_done();
    vectors++;
    if ({bus.state, bus.track_len} !== {2'd0, AW'(0)}) begin
      errors++;
      $display("FAIL empty_rec: state=%0d tlen=%0d, want 0/0", bus.state, bus.track_len);
    end
    m_tlen = 0;
  endtask

  task automatic test_ignored();
    int unsigned w0;
    pulse_play();
    vectors++;
    if ({bus.state, bus.load_req} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL play_no_track: state=%0d lreq=%0b, want 0/0", bus.state, bus.load_req);
    end
    bus.rec_cmd = 1'b1; bus.play_cmd = 1'b1; bus.stop_cmd = 1'b1;
    step();
    bus.rec_cmd = 1'b0; bus.play_cmd = 1'b0; bus.stop_cmd = 1'b0;
    vectors++;
    if ({bus.state, bus.store_req, bus.load_req} !== {2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL all_cmds_idle: state=%0d sreq=%0b lreq=%0b, want 0/0/0",
               bus.state, bus.store_req, bus.load_req);
    end
    pulse_rec();
    w0 = wr_cnt;
    tick(); repeat (4) step();
    tick(); repeat (4) step();
    pulse_rec();
    pulse_play();
    vectors++;
    if ({bus.state, bus.playhead, bus.store_req, bus.load_req} !== {2'd1, AW'(2), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rec_ignores_cmds: state=%0d ph=%0d sreq=%0b lreq=%0b, want 1/2/1/0",
               bus.state, bus.playhead, bus.store_req, bus.load_req);
    end
    pulse_stop();
    repeat (5) step();
    pulse_done();
    vectors++;
    if ({bus.track_len, wr_cnt - w0} !== {AW'(2), 32'd2}) begin
      errors++;
      $display("FAIL rec_two: tlen=%0d wr=%0d, want 2/2", bus.track_len, wr_cnt - w0);
    end
    m_tlen = 2;
  endtask

  task automatic test_stop_tick();
    int unsigned r0;
    pulse_play();
    r0 = rd_cnt;
    tick(); repeat (3) step();
    bus.stop_cmd = 1'b1; bus.sample_tick = 1'b1;
    step();
    bus.stop_cmd = 1'b0; bus.sample_tick = 1'b0;
    vectors++;
    if ({bus.state, bus.rd_en, bus.playhead, bus.load_req} !== {2'd0, 1'b0, AW'(0), 1'b0}) begin
      errors++;
      $display("FAIL stop_with_tick: state=%0d rd=%0b ph=%0d lreq=%0b, want 0/0/0/0",
               bus.state, bus.rd_en, bus.playhead, bus.load_req);
    end
    step();
    vectors++;
    if (rd_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL stop_tick_rd_count: got %0d, want 1", rd_cnt - r0);
    end
  endtask

  task automatic test_async_reset();
    pulse_rec();
    for (int unsigned k = 0; k < 3; k++) begin
      tick(); repeat (3) step();
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.state, bus.playhead, bus.track_len, bus.overflow, bus.store_req,
         bus.load_req, bus.wr_en, bus.rd_en} !== '0) begin
      errors++;
      $display("FAIL async_reset: state=%0d ph=%0d tlen=%0d sreq=%0b, want all 0",
               bus.state, bus.playhead, bus.track_len, bus.store_req);
    end
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;
    step();
    m_tlen = 0;
    pulse_play();
    vectors++;
    if ({bus.state, bus.track_len, bus.load_req} !== {2'd0, AW'(0), 1'b0}) begin
      errors++;
      $display("FAIL after_reset: state=%0d tlen=%0d lreq=%0b, want 0/0/0",
               bus.state, bus.track_len, bus.load_req);
    end
  endtask

  initial begin
    bus.rec_cmd = 1'b0; bus.play_cmd = 1'b0; bus.stop_cmd = 1'b0;
    bus.sample_tick = 1'b0; bus.store_done = 1'b0;
    test_reset();
    test_record(5, 1'b1);
`ifdef TRANSPORT_LOOP_EN
    test_play(12);
`else
    test_play(5);
`endif
    test_overflow();
    test_ignored();
    test_stop_tick();
    repeat (4) begin
      test_record($urandom_range(1, MAXS - 1), 1'b0);
      test_play($urandom_range(1, 12));
    end
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
